// File: rtl/main_control_fsm.sv
// Multicycle CPU main control: Moore FSM driving datapath controls from the current state.
// Latency: outputs decode combinationally from state; illegal_op is registered (one cycle after DECODE).
// Backpressure: none; advances every clock, sampling opcode only in DECODE (latched copy used in MEMADR).
// Optional feature: define ADDI_EN to add ADDIEXEC/ADDIWB states for opcode 001000.
module main_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       branch,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
`ifdef ADDI_EN
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
`endif
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  state_t     state_q;
  state_t     state_d;
  logic [5:0] opcode_q;
  logic       dec_illegal;

  assign state = state_q;

  // State register; unused codes never load here because next-state defaults to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Opcode is captured on leaving DECODE so MEMADR sees the instruction's own opcode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q   <= 6'd0;
      illegal_op <= 1'b0;
    end else begin
      if (state_q == DECODE) begin
        opcode_q <= opcode;
      end
      illegal_op <= dec_illegal;
    end
  end

  // Next-state logic; only DECODE and MEMADR look at opcode.
  always_comb begin
    state_d     = FETCH;
    dec_illegal = 1'b0;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = EXECUTE;
          OP_LW, OP_SW:  state_d = MEMADR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
`ifdef ADDI_EN
          OP_ADDI:       state_d = ADDIEXEC;
`endif
          default: begin
            state_d     = FETCH;
            dec_illegal = 1'b1;
          end
        endcase
      end
      MEMADR:   state_d = (opcode_q == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECUTE:  state_d = ALUWB;
`ifdef ADDI_EN
      ADDIEXEC: state_d = ADDIWB;
`endif
      default:  state_d = FETCH;
    endcase
  end

  // Moore output decode; anything not named for a state stays 0.
  always_comb begin
    alu_op     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    i_or_d     = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      DECODE:   alu_src_b = 2'b11;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMREAD:  i_or_d = 1'b1;
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWRITE: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
`ifdef ADDI_EN
      ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB:   reg_write = 1'b1;
`endif
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset; both are fixed.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instr[31:26], sampled only in DECODE.
- alu_op  out  2  to ALU control decoder: 00 add, 01 subtract, 10 func-defined.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- pc_write  out  1  unconditional PC load.
- branch  out  1  PC load qualified by zero.
- i_or_d  out  1  0 = instruction address, 1 = data address.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- reg_write  out  1  register file write.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = memory data.
- illegal_op  out  1  one-cycle pulse flagging an unsupported opcode.
- state  out  4  current state code, for debug.

Function
REQ-003 Moore FSM; every output except illegal_op SHALL decode combinationally from state only; any output not listed for a state is 0.
REQ-004 State codes and asserted outputs:
- FETCH=0: ir_write, pc_write, alu_src_b=01.
- DECODE=1: alu_src_b=11.
- MEMADR=2: alu_src_a, alu_src_b=10.
- MEMREAD=3: i_or_d.
- MEMWB=4: reg_write, mem_to_reg.
- MEMWRITE=5: i_or_d, mem_write.
- EXECUTE=6: alu_src_a, alu_op=10.
- ALUWB=7: reg_write, reg_dst.
- BRANCH=8: alu_src_a, alu_op=01, pc_src=01, branch.
- ADDIEXEC=9: alu_src_a, alu_src_b=10.
- ADDIWB=10: reg_write.
- JUMP=11: pc_src=10, pc_write.
REQ-005 Fixed transitions: FETCH->DECODE. MEMREAD->MEMWB. EXECUTE->ALUWB. ADDIEXEC->ADDIWB.
REQ-006 Transitions back to FETCH: MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP.
REQ-007 DECODE SHALL branch on opcode:
- 000000 -> EXECUTE.
- 100011 or 101011 -> MEMADR.
- 000100 -> BRANCH.
- 000010 -> JUMP.
- 001000 -> ADDIEXEC (only when ADDI_EN is defined).
- any other opcode -> FETCH.
REQ-008 MEMADR SHALL go to MEMREAD if the opcode latched at DECODE is 100011, else to MEMWRITE; opcode is registered on leaving DECODE.
REQ-009 Cycles per instruction (FETCH through the last state, inclusive): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported 2.
REQ-010 illegal_op SHALL be a registered pulse, high for exactly the first cycle after a DECODE that took the unsupported exit; otherwise 0.
REQ-011 Unused codes 12-15 SHALL go to FETCH on the next edge, with all outputs 0 while there.
REQ-012 Only DECODE and MEMADR sample inputs; opcode changes in any other state SHALL have no effect.

Reset
REQ-013 rst SHALL force state=FETCH and clear the latched opcode and illegal_op immediately, without waiting for clk.
REQ-014 While rst is high, outputs SHALL equal the FETCH decode: ir_write=1, pc_write=1, alu_src_b=01, all others 0.
REQ-015 Reset asserted mid-instruction SHALL abandon it; the first state after release is FETCH, then DECODE on the following edge.

Configuration
REQ-016 Macro ADDI_EN:
- Defined: ADDIEXEC/ADDIWB exist and opcode 001000 follows REQ-007.
- Undefined: both states are removed, 001000 is unsupported (DECODE->FETCH, illegal_op pulses), and codes 9-10 behave per REQ-011.

Verification
REQ-017 Bench SHALL cover:
- opcode=100011 after reset -> states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4.
- opcode=101011 -> states 0,1,2,5,0; mem_write=1 for exactly 1 cycle with i_or_d=1.
- opcode=000000 -> states 0,1,6,7,0; alu_op=10 in state 6; reg_dst=1 in state 7.
- opcode=000100 then 000010 -> 0,1,8,0 with alu_op=01 and branch=1; then 0,1,11,0 with pc_src=10 and pc_write=1.
- opcode=001000: with ADDI_EN -> 0,1,9,10,0; without it -> 0,1,0 and illegal_op=1 for 1 cycle.
- rst pulsed between clock edges while in state 3 -> state=0 immediately, illegal_op=0, next edge -> state 1.
